seq_adder: RTL and testbench

SEQ_ADDER -- requirements
Module: seq_adder

---
 rtl/seq_adder.sv | 120 ++++++++++++
 tb/tb_seq_adder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_adder.sv
// Multi-cycle adder: sums WIDTH-bit operands CHUNK bits per clock, LSB slice first.
// Define SEQ_ADDER_OVF_EN to add the signed-overflow output ovf.
module seq_adder #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SEQ_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   // state | meaning
   // IDLE  | waiting for start
   // RUN   | adding one CHUNK slice per edge, busy=1
   // DONE  | result presented, done=1 for this cycle only
   localparam int N     = WIDTH / CHUNK;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state, state_next;
   logic               load;
   logic [WIDTH-1:0]   a_r, b_r, acc, acc_next;
   logic               carry;
   logic [IDX_W-1:0]   idx;
   logic               last;
   logic [CHUNK-1:0]   a_sl, b_sl;
   logic [CHUNK:0]     slice_res;
   int                 base;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      load       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last) state_next = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               load       = 1'b1;
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Slices land in the private accumulator; sum only sees the finished word.
   always_comb begin
      base      = int'(idx) * CHUNK;
      last      = (idx == IDX_W'(N - 1));
      a_sl      = a_r[base +: CHUNK];
      b_sl      = b_r[base +: CHUNK];
      slice_res = {1'b0, a_sl} + {1'b0, b_sl} + (CHUNK + 1)'(carry);
      acc_next  = acc;
      acc_next[base +: CHUNK] = slice_res[CHUNK-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_r   <= '0;
         b_r   <= '0;
         acc   <= '0;
         carry <= 1'b0;
         idx   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
`ifdef SEQ_ADDER_OVF_EN
         ovf   <= 1'b0;
`endif
      end else if (load) begin
         a_r   <= a;
         b_r   <= b;
         carry <= cin;
         acc   <= '0;
         idx   <= '0;
      end else if (state == RUN) begin
         acc   <= acc_next;
         carry <= slice_res[CHUNK];
         idx   <= idx + IDX_W'(1);
         if (last) begin
            sum  <= acc_next;
            cout <= slice_res[CHUNK];
`ifdef SEQ_ADDER_OVF_EN
            ovf  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                    (acc_next[WIDTH-1] != a_r[WIDTH-1]);
`endif
         end
      end
   end

endmodule

// File: tb/tb_seq_adder.sv
// Bench for seq_adder: cycle model for the 8/4 instance plus directed jobs on
// 8/8 and 16/1 instances. Covers ovf when SEQ_ADDER_OVF_EN is defined.
module tb_seq_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1, start = 1'b0, sel = 1'b0, cin = 1'b0;
   logic [7:0] a = '0, b = '0;
   logic       start8, startf;
   assign start8 = start & ~sel;
   assign startf = start & sel;

   logic       busy8, done8, cout8, busyf, donef, coutf;
   logic [7:0] sum8, sumf;
   logic        start16 = 1'b0, cin16 = 1'b0, busy16, done16, cout16;
   logic [15:0] a16 = '0, b16 = '0, sum16;
`ifdef SEQ_ADDER_OVF_EN
   logic ovf8, ovff, ovf16;
`endif

   seq_adder #(.WIDTH(8), .CHUNK(4)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a), .b(b), .cin(cin),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SEQ_ADDER_OVF_EN
      , .ovf(ovf8)
`endif
   );

   seq_adder #(.WIDTH(8), .CHUNK(8)) dutf (
      .clk(clk), .rst(rst), .start(startf), .a(a), .b(b), .cin(cin),
      .busy(busyf), .done(donef), .sum(sumf), .cout(coutf)
`ifdef SEQ_ADDER_OVF_EN
      , .ovf(ovff)
`endif
   );

   seq_adder #(.WIDTH(16), .CHUNK(1)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
      .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
`ifdef SEQ_ADDER_OVF_EN
      , .ovf(ovf16)
`endif
   );

   logic       o_busy, o_done, o_cout, o_ovf;
   logic [7:0] o_sum;
   always_comb begin
      o_busy = sel ? busyf : busy8;
      o_done = sel ? donef : done8;
      o_sum  = sel ? sumf  : sum8;
      o_cout = sel ? coutf : cout8;
`ifdef SEQ_ADDER_OVF_EN
      o_ovf  = sel ? ovff  : ovf8;
`else
      o_ovf  = 1'b0;
`endif
   end

   int total = 0, bad = 0, cycle = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // {ovf, cout, sum} of a+b+c, straight from the arithmetic definition
   function automatic logic [9:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic c);
      logic [8:0] full;
      logic       ov;
      full = {1'b0, x} + {1'b0, y} + 9'(c);
      ov   = (x[7] == y[7]) && (full[7] != x[7]);
      return {ov, full};
   endfunction

   // Model of the 8/4 instance: a job occupies 2 busy cycles, then one done cycle.
   int         m_rem = 0;
   bit         m_done = 1'b0, m_cout = 1'b0, m_ovf = 1'b0, p_cout = 1'b0, p_ovf = 1'b0;
   logic [7:0] m_sum = '0, p_sum = '0;

   always @(posedge clk) begin
      cycle <= cycle + 1;
      if (rst) begin
         m_rem <= 0; m_done <= 1'b0; m_sum <= '0; m_cout <= 1'b0; m_ovf <= 1'b0;
      end else if (m_rem > 0) begin
         m_rem <= m_rem - 1;
         if (m_rem == 1) begin
            m_done <= 1'b1; m_sum <= p_sum; m_cout <= p_cout; m_ovf <= p_ovf;
         end
      end else begin
         m_done <= 1'b0;
         if (start8) begin
            m_rem <= 2;
            {p_ovf, p_cout, p_sum} <= ref_add(a, b, cin);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("m_busy", busy8, m_rem > 0);
         check("m_done", done8, m_done);
         check("m_sum", sum8, m_sum);
         check("m_cout", cout8, m_cout);
`ifdef SEQ_ADDER_OVF_EN
         check("m_ovf", ovf8, m_ovf);
`endif
      end
   end

   task automatic job(input bit s, input logic [7:0] ta, input logic [7:0] tb2, input logic tc,
                      input logic [7:0] es, input logic ec, input logic eo, input bit tog, input int n);
      int cyc, busy_n;
      bit seen;
      cyc = 0; busy_n = 0; seen = 1'b0;
      @(posedge clk); #1;
      sel = s; a = ta; b = tb2; cin = tc; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 1; i <= n + 5 && !seen; i++) begin
         @(negedge clk);
         if (o_done) begin
            seen = 1'b1; cyc = i;
         end else begin
            if (o_busy) busy_n++;
            if (tog && o_busy) begin
               a = ~a; b = b + 8'h3; cin = ~cin; start = ~start;
            end
         end
      end
      start = 1'b0;
      check("done_seen", seen, 1);
      check("latency", cyc, n + 1);
      check("busy_cycles", busy_n, n);
      check("sum", o_sum, es);
      check("cout", o_cout, ec);
`ifdef SEQ_ADDER_OVF_EN
      check("ovf", o_ovf, eo);
`endif
      @(negedge clk);
      check("done_single", o_done, 0);
      check("sum_hold", o_sum, es);
   endtask

   logic [7:0] ba [3] = '{8'h12, 8'h80, 8'h0F};
   logic [7:0] bb [3] = '{8'h34, 8'h80, 8'hF0};
   logic       bc [3] = '{1'b0, 1'b1, 1'b1};
   logic [7:0] bs [3] = '{8'h46, 8'h01, 8'h00};
   logic       bo [3] = '{1'b0, 1'b1, 1'b1};

   initial begin
      int  last_t, t, busy_n;
      bit  seen;
      repeat (2) @(posedge clk);
      #1 chk_en = 1'b1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy", busy8, 0);
      check("rst_done", done8, 0);
      check("rst_sum", sum8, 0);
      check("rst_cout", cout8, 0);

      job(1'b0, 8'h55, 8'h77, 1'b1, 8'hCD, 1'b0, 1'b1, 1'b0, 2);
      job(1'b0, 8'hAA, 8'h01, 1'b0, 8'hAB, 1'b0, 1'b0, 1'b1, 2);
      job(1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2);
      job(1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 2);
      job(1'b1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1);
      job(1'b1, 8'h55, 8'h77, 1'b1, 8'hCD, 1'b0, 1'b1, 1'b0, 1);

      // start held high across three jobs
      @(posedge clk); #1;
      sel = 1'b0; a = ba[0]; b = bb[0]; cin = bc[0]; start = 1'b1;
      last_t = 0;
      for (int j = 0; j < 3; j++) begin
         @(posedge clk); #1;
         if (j < 2) begin
            a = ba[j+1]; b = bb[j+1]; cin = bc[j+1];
         end else begin
            start = 1'b0;
         end
         seen = 1'b0; t = 0;
         for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            if (done8) begin seen = 1'b1; t = cycle; end
         end
         check("b2b_seen", seen, 1);
         check("b2b_sum", sum8, bs[j]);
         check("b2b_cout", cout8, bo[j]);
         if (j > 0) check("b2b_spacing", t - last_t, 3);
         last_t = t;
      end
      start = 1'b0;

      // reset in the second RUN cycle aborts the job
      @(posedge clk); #1;
      sel = 1'b0; a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_busy", busy8, 0);
      check("abort_done", done8, 0);
      check("abort_sum", sum8, 0);
      check("abort_cout", cout8, 0);
      repeat (3) begin
         @(negedge clk);
         check("abort_no_done", done8, 0);
      end
      job(1'b0, 8'h3C, 8'hC3, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 2);

      // 16-bit, one bit per cycle, full carry ripple
      @(posedge clk); #1;
      a16 = 16'hFFFF; b16 = 16'h0000; cin16 = 1'b1; start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      seen = 1'b0; t = 0; busy_n = 0;
      for (int i = 1; i <= 30 && !seen; i++) begin
         @(negedge clk);
         if (done16) begin seen = 1'b1; t = i; end
         else if (busy16) busy_n++;
      end
      check("w16_seen", seen, 1);
      check("w16_latency", t, 17);
      check("w16_busy", busy_n, 16);
      check("w16_sum", sum16, 16'h0000);
      check("w16_cout", cout16, 1);
`ifdef SEQ_ADDER_OVF_EN
      check("w16_ovf", ovf16, 0);
`endif

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
